sync_fifo_flags: RTL and testbench

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 32 +++
 rtl/sync_fifo_flags.sv | 124 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo_flags slice.
//   op_e : push/pop operation code, decoded from {pop_accept, push_accept}.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PUSH = 2'b01,
        POP  = 2'b10,
        BOTH = 2'b11
    } op_e;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// FIFO storage array: DEPTH x DATA_W, one synchronous write port and one
// asynchronous read port. No reset; contents persist across reset/flush.
//   clk      : write clock (rising edge)
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : write data
//   raddr_i  : read index
//   rdata_o  : combinational read data
module fifo_mem #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem

// File: rtl/sync_fifo_flags.sv
// Synchronous first-word-fall-through FIFO with level flags, registered
// occupancy counter, synchronous flush and sticky overflow/underflow flags.
//   clk, reset          : clock (rising edge), async active-high reset
//   push_i, push_data_i : write request and data
//   pop_i, pop_data_o   : read request and head entry (zero latency)
//   flush_i             : synchronous empty command (wins over push/pop)
//   err_clr_i           : clears sticky error flags
//   full_o, empty_o, almost_full_o, almost_empty_o : level flags
//   count_o             : occupancy 0..DEPTH
//   overflow_o, underflow_o : sticky error flags
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned AE_THRESH = 1,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned PW       = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    input  logic              flush_i,
    input  logic              err_clr_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [PW-1:0]     count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          full, empty;
    logic          push_acc, pop_acc;
    op_e           op;

    // Flags decode only from the count register.
    assign empty = (count_q == '0);
    assign full  = (count_q == PW'(DEPTH));

    always_comb begin
        // A pop frees a slot in the same cycle, so push is allowed when full.
        push_acc = push_i & (~full | pop_i) & ~flush_i;
        pop_acc  = pop_i & ~empty & ~flush_i;
        op       = op_e'({pop_acc, push_acc});

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (op)
            IDLE: ;
            PUSH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
            POP: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
            BOTH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            default: ;
        endcase

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // New error in the clear cycle wins over the clear.
        ovf_d = (push_i & full & ~pop_i & ~flush_i) | (ovf_q & ~err_clr_i);
        udf_d = (pop_i & empty & ~flush_i) | (udf_q & ~err_clr_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (push_data_i),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (pop_data_o)
    );

    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= PW'(AF_THRESH));
    assign almost_empty_o = (count_q <= PW'(AE_THRESH));
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule : sync_fifo_flags

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       reset;
    logic       push_i;
    logic [7:0] push_data_i;
    logic       pop_i;
    logic [7:0] pop_data_o;
    logic       flush_i;
    logic       err_clr_i;
    logic       full_o, empty_o, almost_full_o, almost_empty_o;
    logic [2:0] count_o;
    logic       overflow_o, underflow_o;

    int checks = 0;
    int errors = 0;

    sync_fifo_flags #(
        .DEPTH     (4),
        .DATA_W    (8),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .push_i         (push_i),
        .push_data_i    (push_data_i),
        .pop_i          (pop_i),
        .pop_data_o     (pop_data_o),
        .flush_i        (flush_i),
        .err_clr_i      (err_clr_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus, then return 1 time unit after the edge.
    task automatic cyc(input logic psh, input logic [7:0] d, input logic pp,
                       input logic fl, input logic clr);
        push_i = psh; push_data_i = d; pop_i = pp; flush_i = fl; err_clr_i = clr;
        @(posedge clk); #1;
        push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; err_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        push_i = 0; push_data_i = 0; pop_i = 0; flush_i = 0; err_clr_i = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({count_o, empty_o, almost_empty_o, full_o, almost_full_o, overflow_o, underflow_o}
            !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: count=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b, expected 0 1 1 0 0 0 0",
                     count_o, empty_o, almost_empty_o, full_o, almost_full_o, overflow_o, underflow_o);
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic       exp_af [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_f  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
            checks++;
            if ({count_o, almost_full_o, full_o} !== {3'(i + 1), exp_af[i], exp_f[i]}) begin
                errors++;
                $display("FAIL fill_%0d: count=%0d af=%b f=%b, expected %0d %b %b",
                         i, count_o, almost_full_o, full_o, i + 1, exp_af[i], exp_f[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            pop_i = 1'b1; #1;
            checks++;
            if (pop_data_o !== vals[i]) begin
                errors++;
                $display("FAIL drain_%0d: data=%h, expected %h", i, pop_data_o, vals[i]);
            end
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if ({empty_o, count_o} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL drain_empty: empty=%b count=%0d, expected 1 0", empty_o, count_o);
        end
    endtask

    task automatic test_overflow();
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({overflow_o, count_o} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL overflow_set: ov=%b count=%0d, expected 1 4", overflow_o, count_o);
        end
        pop_i = 1'b1; #1;
        checks++;
        if (pop_data_o !== 8'h11) begin
            errors++;
            $display("FAIL overflow_head: data=%h, expected 11", pop_data_o);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({overflow_o, count_o} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL overflow_sticky: ov=%b count=%0d, expected 1 3", overflow_o, count_o);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: ov=%b, expected 0", overflow_o);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        push_i = 1'b1; push_data_i = 8'h66; pop_i = 1'b1; #1;
        checks++;
        if (pop_data_o !== 8'h11) begin
            errors++;
            $display("FAIL both_full_head: data=%h, expected 11", pop_data_o);
        end
        cyc(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({count_o, full_o, overflow_o} !== {3'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL both_full_count: count=%0d f=%b ov=%b, expected 4 1 0",
                     count_o, full_o, overflow_o);
        end
        for (int i = 0; i < 4; i++) begin
            pop_i = 1'b1; #1;
            checks++;
            if (pop_data_o !== exp[i]) begin
                errors++;
                $display("FAIL both_drain_%0d: data=%h, expected %h", i, pop_data_o, exp[i]);
            end
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (empty_o !== 1'b1) begin
            errors++;
            $display("FAIL both_empty: empty=%b, expected 1", empty_o);
        end
    endtask

    task automatic test_underflow();
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({underflow_o, count_o, empty_o} !== {1'b1, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL underflow_set: un=%b count=%0d e=%b, expected 1 0 1",
                     underflow_o, count_o, empty_o);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: un=%b, expected 0", underflow_o);
        end
        cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({count_o, pop_data_o, underflow_o} !== {3'd1, 8'h77, 1'b1}) begin
            errors++;
            $display("FAIL push_pop_empty: count=%0d data=%h un=%b, expected 1 77 1",
                     count_o, pop_data_o, underflow_o);
        end
        // Error raised in the clear cycle must survive the clear.
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({underflow_o, empty_o} !== {1'b1, 1'b1}) begin
            errors++;
            $display("FAIL clear_vs_new_err: un=%b e=%b, expected 1 1", underflow_o, empty_o);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h88, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({count_o, empty_o, overflow_o, underflow_o} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flush: count=%0d e=%b ov=%b un=%b, expected 0 1 0 0",
                     count_o, empty_o, overflow_o, underflow_o);
        end
        cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({count_o, pop_data_o} !== {3'd1, 8'h99}) begin
            errors++;
            $display("FAIL flush_then_push: count=%0d data=%h, expected 1 99", count_o, pop_data_o);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        // Pointers sit at non-zero positions before the reset.
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({count_o, underflow_o} !== {3'd2, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset: count=%0d un=%b, expected 2 1", count_o, underflow_o);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({count_o, empty_o, almost_empty_o, full_o, almost_full_o, overflow_o, underflow_o}
            !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: count=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b, expected 0 1 1 0 0 0 0",
                     count_o, empty_o, almost_empty_o, full_o, almost_full_o, overflow_o, underflow_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        pop_i = 1'b1; #1;
        checks++;
        if ({pop_data_o, count_o} !== {8'hAA, 3'd1}) begin
            errors++;
            $display("FAIL reset_then_push: data=%h count=%0d, expected aa 1", pop_data_o, count_o);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (empty_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_final_empty: empty=%b, expected 1", empty_o);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_push_pop_full();
        test_underflow();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sync_fifo_flags
